epass_lane_arbiter: RTL and testbench

//  Shares one E-pass check engine among NUM_LANES toll-lane controllers. Each lane controller

---
 rtl/epass_pkg.sv | 19 +
 rtl/epass_lane_arbiter_rr_pick.sv | 35 +++
 rtl/epass_lane_arbiter.sv | 143 ++++++++++++++
 tb/tb_epass_lane_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/epass_pkg.sv
// Verdict codes, FSM state encodings and verdict normalisation shared by the lane arbiter.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package epass_pkg;

  localparam logic [1:0] EPASS_PASS = 2'b10;
  localparam logic [1:0] EPASS_REJ  = 2'b01;
  localparam logic [1:0] EPASS_PEND = 2'b00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  // Anything the engine reports other than a clean pass is a reject at the gate.
  function automatic logic [1:0] epass_norm(input logic [1:0] code);
    return (code == EPASS_PASS) ? EPASS_PASS : EPASS_REJ;
  endfunction

endpackage

// File: rtl/epass_lane_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr; lane 0 always wins with PRIORITY_LANE_EN.
// Latency: combinational. Backpressure: none, caller samples pick only when it can grant.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    for (int off = 0; off < N; off++) begin
      j = int'(ptr) + off;
      if (j >= N) j = j - N;
      if (!any && req[IW'(j)]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
`ifdef PRIORITY_LANE_EN
    if (req[0]) idx = '0;
`endif
    if (any) pick = {{(N-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/epass_lane_arbiter.sv
// Shares one E-pass check engine among lanes; PRIORITY_LANE_EN makes lane 0 win arbitration.
// Latency: req -> grant 1 cycle, -> chk_start 2 cycles; chk_done -> lane_res_vld 2 cycles.
// Backpressure: lanes hold lane_req until their result strobe; the engine is never stalled.
module epass_lane_arbiter
  import epass_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int ID_W        = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_LANES-1:0]      lane_req,
  input  logic [NUM_LANES*ID_W-1:0] lane_id,
  output logic [NUM_LANES-1:0]      lane_grant,
  output logic [NUM_LANES-1:0]      lane_res_vld,
  output logic [1:0]                lane_res,
  output logic                      lane_timeout,
  output logic                      chk_start,
  output logic [ID_W-1:0]           chk_id,
  input  logic                      chk_done,
  input  logic [1:0]                chk_result
);

  localparam int IW = $clog2(NUM_LANES);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]           state, state_nxt;
  logic [IW-1:0]        rr_ptr, rr_ptr_nxt, idx_q, idx_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [1:0]           res_q, res_nxt;
  logic                 to_q, to_nxt;
  logic [NUM_LANES-1:0] grant_nxt, res_vld_nxt;
  logic [1:0]           lane_res_nxt;
  logic                 lane_to_nxt, chk_start_nxt;
  logic [ID_W-1:0]      chk_id_nxt;
  logic [NUM_LANES-1:0] pick;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  rr_pick #(.N(NUM_LANES), .IW(IW)) u_pick (
    .req  (lane_req),
    .ptr  (rr_ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_any) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT:   if (chk_done || timer == T_LAST) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_nxt     = lane_grant;
    res_vld_nxt   = '0;
    lane_res_nxt  = lane_res;
    lane_to_nxt   = lane_timeout;
    chk_start_nxt = 1'b0;
    chk_id_nxt    = chk_id;
    rr_ptr_nxt    = rr_ptr;
    idx_nxt       = idx_q;
    timer_nxt     = timer;
    res_nxt       = res_q;
    to_nxt        = to_q;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_nxt  = pick;
          idx_nxt    = pick_idx;
          chk_id_nxt = lane_id[int'(pick_idx)*ID_W +: ID_W];
        end
      end
      ST_ISSUE: begin
        chk_start_nxt = 1'b1;
        timer_nxt     = '0;
      end
      ST_WAIT: begin
        if (timer != '1) timer_nxt = timer + TW'(1);
        // A verdict arriving on the last allowed cycle still beats the timeout.
        if (chk_done) begin
          res_nxt = epass_norm(chk_result);
          to_nxt  = 1'b0;
        end else if (timer == T_LAST) begin
          res_nxt = EPASS_REJ;
          to_nxt  = 1'b1;
        end
      end
      ST_REPORT: begin
        res_vld_nxt  = lane_grant;
        grant_nxt    = '0;
        lane_res_nxt = res_q;
        lane_to_nxt  = to_q;
        rr_ptr_nxt   = (idx_q == IW'(NUM_LANES - 1)) ? '0 : idx_q + IW'(1);
`ifdef PRIORITY_LANE_EN
        if (idx_q == '0) rr_ptr_nxt = rr_ptr;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_grant   <= '0;
      lane_res_vld <= '0;
      lane_res     <= EPASS_PEND;
      lane_timeout <= 1'b0;
      chk_start    <= 1'b0;
      chk_id       <= '0;
      rr_ptr       <= '0;
      idx_q        <= '0;
      timer        <= '0;
      res_q        <= EPASS_PEND;
      to_q         <= 1'b0;
    end else begin
      lane_grant   <= grant_nxt;
      lane_res_vld <= res_vld_nxt;
      lane_res     <= lane_res_nxt;
      lane_timeout <= lane_to_nxt;
      chk_start    <= chk_start_nxt;
      chk_id       <= chk_id_nxt;
      rr_ptr       <= rr_ptr_nxt;
      idx_q        <= idx_nxt;
      timer        <= timer_nxt;
      res_q        <= res_nxt;
      to_q         <= to_nxt;
    end
  end

endmodule

// File: tb/tb_epass_lane_arbiter.sv
// Directed vector bench for epass_lane_arbiter (4 lanes, 16-bit IDs, 8-cycle timeout).
module tb_epass_lane_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  lane_req;
  logic [63:0] lane_id;
  logic [3:0]  lane_grant, lane_res_vld;
  logic [1:0]  lane_res;
  logic        lane_timeout, chk_start;
  logic [15:0] chk_id;
  logic        chk_done;
  logic [1:0]  chk_result;

  int n_chk  = 0;
  int n_pass = 0;

  epass_lane_arbiter #(.NUM_LANES(4), .ID_W(16), .TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .lane_req     (lane_req),
    .lane_id      (lane_id),
    .lane_grant   (lane_grant),
    .lane_res_vld (lane_res_vld),
    .lane_res     (lane_res),
    .lane_timeout (lane_timeout),
    .chk_start    (chk_start),
    .chk_id       (chk_id),
    .chk_done     (chk_done),
    .chk_result   (chk_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  raise;
    logic [63:0] ids;
    int          k;       // WAIT cycle on which chk_done is driven; -1 = never
    logic [1:0]  code;
    logic [3:0]  exp_grant;
    logic [15:0] exp_id;
    logic [1:0]  exp_res;
    logic        exp_to;
  } vec_t;

  localparam logic [63:0] ALL = 64'h4444_3333_2222_1111;
`ifdef PRIORITY_LANE_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] raise,
                              input logic [63:0] ids, input int k, input logic [1:0] code,
                              input logic [3:0] eg, input logic [15:0] eid,
                              input logic [1:0] er, input logic eto);
    vec_t v;
    v.req = req; v.raise = raise; v.ids = ids; v.k = k; v.code = code;
    v.exp_grant = eg; v.exp_id = eid; v.exp_res = er; v.exp_to = eto;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int cyc;
    logic [3:0] g;
    lane_req = v.req;
    lane_id  = v.ids;
    cyc = 0;
    while (lane_grant == 4'b0 && cyc < 12) begin tick(); cyc++; end
    check({nm, ".grant"}, lane_grant, v.exp_grant);
    check({nm, ".grant_lat"}, cyc, 1);
    g = lane_grant;
    tick();
    check({nm, ".chk_start"}, chk_start, 1);
    check({nm, ".chk_id"}, chk_id, v.exp_id);
    lane_req = lane_req | v.raise;
    cyc = 0;
    while (cyc < 20) begin
      chk_done   = (cyc == v.k);
      chk_result = v.code;
      if (cyc == 1) check({nm, ".start_pulse"}, chk_start, 0);
      if (lane_res_vld != 4'b0) break;
      tick();
      cyc++;
    end
    chk_done = 1'b0;
    check({nm, ".res_vld"}, lane_res_vld, v.exp_grant);
    check({nm, ".res"}, lane_res, v.exp_res);
    check({nm, ".timeout"}, lane_timeout, v.exp_to);
    check({nm, ".res_lat"}, cyc, (v.k < 0) ? 9 : v.k + 2);
    check({nm, ".grant_clr"}, lane_grant, 0);
    lane_req = lane_req & ~g;
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".grant"}, lane_grant, 0);
    check({nm, ".res_vld"}, lane_res_vld, 0);
    check({nm, ".res"}, lane_res, 0);
    check({nm, ".timeout"}, lane_timeout, 0);
    check({nm, ".chk_start"}, chk_start, 0);
    check({nm, ".chk_id"}, chk_id, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    vec_t v;
    logic [3:0] seen;

    tbl[0]  = mk(4'b1111, 0, ALL, 0, 2'b10, 4'b0001, 16'h1111, 2'b10, 0);
    tbl[1]  = mk(4'b1111, 0, ALL, 1, 2'b10, PRIO ? 4'b0001 : 4'b0010,
                 PRIO ? 16'h1111 : 16'h2222, 2'b10, 0);
    tbl[2]  = mk(4'b1111, 0, ALL, 2, 2'b10, PRIO ? 4'b0001 : 4'b0100,
                 PRIO ? 16'h1111 : 16'h3333, 2'b10, 0);
    tbl[3]  = mk(4'b1111, 0, ALL, 0, 2'b10, PRIO ? 4'b0001 : 4'b1000,
                 PRIO ? 16'h1111 : 16'h4444, 2'b10, 0);
    tbl[4]  = mk(4'b1111, 0, ALL, 4, 2'b10, 4'b0001, 16'h1111, 2'b10, 0);
    tbl[5]  = mk(4'b0010, 0, 64'h0000_0000_1234_0000, 3, 2'b10, 4'b0010, 16'h1234, 2'b10, 0);
    tbl[6]  = mk(4'b0100, 0, 64'h0000_ABCD_0000_0000, 1, 2'b11, 4'b0100, 16'hABCD, 2'b01, 0);
    tbl[7]  = mk(4'b1000, 0, 64'hBEEF_0000_0000_0000, 7, 2'b10, 4'b1000, 16'hBEEF, 2'b10, 0);
    tbl[8]  = mk(4'b0001, 0, 64'h0000_0000_0000_CAFE, -1, 2'b10, 4'b0001, 16'hCAFE, 2'b01, 1);
    tbl[9]  = mk(4'b0001, 0, 64'h0000_0000_0000_0F0F, 0, 2'b00, 4'b0001, 16'h0F0F, 2'b01, 0);
    tbl[10] = mk(4'b1100, 0, 64'h9999_8888_0000_0000, 2, 2'b10, 4'b0100, 16'h8888, 2'b10, 0);

    reset = 1'b1; lane_req = '0; lane_id = '0; chk_done = 1'b0; chk_result = 2'b00;
    repeat (2) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Timeout, then a stale verdict arriving in IDLE must be dropped.
    v = mk(4'b1000, 0, 64'h7E7E_0000_0000_0000, -1, 2'b10, 4'b1000, 16'h7E7E, 2'b01, 1);
    run_vec(v, "tmo");
    chk_done = 1'b1; chk_result = 2'b10;
    tick();
    chk_done = 1'b0;
    seen = '0;
    repeat (4) begin tick(); seen = seen | lane_res_vld | lane_grant; end
    check("stale_done.quiet", seen, 0);

    // Reset in WAIT aborts the transaction with no strobe.
    lane_req = 4'b0100; lane_id = 64'h0000_7777_0000_0000;
    repeat (4) tick();
    check("abort.in_wait", chk_id, 16'h7777);
    reset = 1'b1; lane_req = '0;
    tick();
    check_zero("abort");
    reset = 1'b0;
    seen = '0;
    repeat (4) begin tick(); seen = seen | lane_res_vld; end
    check("abort.no_strobe", seen, 0);
    run_vec(mk(4'b0100, 0, 64'h0000_5A5A_0000_0000, 1, 2'b10, 4'b0100, 16'h5A5A, 2'b10, 0), "rereq");

    // Lane 0 raises while lane 1 is being checked.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    run_vec(mk(4'b1110, 4'b0001, ALL, 1, 2'b10, 4'b0010, 16'h2222, 2'b10, 0), "prio1");
    check("prio1.req_left", lane_req, 4'b1101);
    run_vec(mk(4'b1101, 0, ALL, 0, 2'b10, PRIO ? 4'b0001 : 4'b0100,
               PRIO ? 16'h1111 : 16'h3333, 2'b10, 0), "prio2");
    run_vec(mk(PRIO ? 4'b1100 : 4'b1001, 0, ALL, 0, 2'b10, PRIO ? 4'b0100 : 4'b1000,
               PRIO ? 16'h3333 : 16'h4444, 2'b10, 0), "prio3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
